// File: rtl/pool2d_stream_engine_if.sv
// Output stream of the pooling engine: one pooled value per window plus its
// output coordinates and a last-window flag, under a valid/ready handshake.
//   master: engine side  (drives out_data/out_valid/out_row/out_col/out_last)
//   slave : consumer side (drives out_ready)
interface pool2d_stream_engine_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROW_W  = 1,
  parameter int unsigned COL_W  = 1
);
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ROW_W-1:0]         out_row;
  logic [COL_W-1:0]         out_col;
  logic                     out_last;

  modport master (
    output out_data, out_valid, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/pool2d_stream_engine.sv
// 2-D pooling engine: snapshots a row-major activation map on start, walks
// every POOL_K x POOL_K window at STRIDE, reduces it (max or floor-average)
// one element per cycle and streams one value per window.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start, mode  begin pooling (sampled in IDLE); 0=max, 1=average
//   act_map      packed map, element (r,c) at [(r*MAP_W+c)*DATA_W +: DATA_W]
//   busy, done   high outside IDLE; one-cycle pulse after the final handshake
//   out_if       pooled-value stream (master side)
module pool2d_stream_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MAP_H  = 4,
  parameter int unsigned MAP_W  = 4,
  parameter int unsigned POOL_K = 2,
  parameter int unsigned STRIDE = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  input  logic [MAP_H*MAP_W*DATA_W-1:0] act_map,
  output logic                          busy,
  output logic                          done,
  pool2d_stream_engine_if.master        out_if
);

  localparam int unsigned OUT_H     = (MAP_H - POOL_K) / STRIDE + 1;
  localparam int unsigned OUT_W     = (MAP_W - POOL_K) / STRIDE + 1;
  localparam int unsigned NWIN      = POOL_K * POOL_K;
  localparam int unsigned LOG2_NWIN = $clog2(NWIN);
  localparam int unsigned ACC_W     = DATA_W + LOG2_NWIN;
  localparam int unsigned ROW_W     = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned COL_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned K_W       = (POOL_K > 1) ? $clog2(POOL_K) : 1;
  localparam int unsigned MR_W      = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned MC_W      = (MAP_W > 1) ? $clog2(MAP_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EMIT,
    ST_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] snap_q [MAP_H][MAP_W];
  logic signed [DATA_W-1:0] snap_d [MAP_H][MAP_W];
  logic signed [DATA_W-1:0] map_view [MAP_H][MAP_W];
  logic                     mode_q, mode_d;
  logic [ROW_W-1:0]         orow_q, orow_d;
  logic [COL_W-1:0]         ocol_q, ocol_d;
  logic [K_W-1:0]           kr_q, kr_d;
  logic [K_W-1:0]           kc_q, kc_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [MR_W-1:0]          elem_r;
  logic [MC_W-1:0]          elem_c;
  logic signed [DATA_W-1:0] elem;
  logic signed [ACC_W-1:0]  elem_ext;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  avg_val;
  logic signed [DATA_W-1:0] result;
  logic                     first_elem;
  logic                     last_elem;
  logic                     win_last;

  // Unpacked view of the input map, used only for the snapshot.
  for (genvar r = 0; r < MAP_H; r++) begin : g_row
    for (genvar c = 0; c < MAP_W; c++) begin : g_col
      assign map_view[r][c] = act_map[(r*MAP_W+c)*DATA_W +: DATA_W];
    end
  end

  // Window element fetch and reduction step.
  always_comb begin
    elem_r     = MR_W'(32'(orow_q) * STRIDE + 32'(kr_q));
    elem_c     = MC_W'(32'(ocol_q) * STRIDE + 32'(kc_q));
    elem       = snap_q[elem_r][elem_c];
    elem_ext   = ACC_W'(elem);
    first_elem = (kr_q == '0) && (kc_q == '0);
    last_elem  = (kr_q == K_W'(POOL_K - 1)) && (kc_q == K_W'(POOL_K - 1));
    win_last   = (orow_q == ROW_W'(OUT_H - 1)) && (ocol_q == COL_W'(OUT_W - 1));
    if (mode_q) begin
      acc_next = first_elem ? elem_ext : acc_q + elem_ext;
    end else begin
      acc_next = (first_elem || (elem_ext > acc_q)) ? elem_ext : acc_q;
    end
    // Arithmetic shift gives floor toward -inf; the mean always fits DATA_W.
    avg_val = acc_next >>> LOG2_NWIN;
    result  = mode_q ? DATA_W'(avg_val) : DATA_W'(acc_next);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mode_d  = mode_q;
    orow_d  = orow_q;
    ocol_d  = ocol_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = map_view;
          mode_d  = mode;
          orow_d  = '0;
          ocol_d  = '0;
          kr_d    = '0;
          kc_d    = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_next;
        if (last_elem) begin
          data_d  = result;
          valid_d = 1'b1;
          last_d  = win_last;
          kr_d    = '0;
          kc_d    = '0;
          state_d = ST_EMIT;
        end else if (kc_q == K_W'(POOL_K - 1)) begin
          kc_d = '0;
          kr_d = kr_q + K_W'(1);
        end else begin
          kc_d = kc_q + K_W'(1);
        end
      end
      ST_EMIT: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            if (ocol_q == COL_W'(OUT_W - 1)) begin
              ocol_d = '0;
              orow_d = orow_q + ROW_W'(1);
            end else begin
              ocol_d = ocol_q + COL_W'(1);
            end
            state_d = ST_ACCUM;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      snap_q  <= '{default: '0};
      mode_q  <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mode_q  <= mode_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_row   = orow_q;
  assign out_if.out_col   = ocol_q;
  assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_pool2d_stream_engine.sv
// Bench for pool2d_stream_engine: a STRIDE=2 and a STRIDE=1 instance share the
// same stimulus; captured streams are compared with a window-by-window model.
module tb_pool2d_stream_engine;

  typedef struct {
    int d;
    int r;
    int c;
    bit l;
  } rec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic [255:0] act_map;
  logic         rdy;
  logic         busy_a, done_a, busy_b, done_b;

  pool2d_stream_engine_if #(.DATA_W(16), .ROW_W(1), .COL_W(1)) if_a ();
  pool2d_stream_engine_if #(.DATA_W(16), .ROW_W(2), .COL_W(2)) if_b ();

  assign if_a.out_ready = rdy;
  assign if_b.out_ready = rdy;

  pool2d_stream_engine #(.STRIDE(2)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .act_map(act_map),
    .busy(busy_a), .done(done_a), .out_if(if_a)
  );

  pool2d_stream_engine #(.STRIDE(1)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .act_map(act_map),
    .busy(busy_b), .done(done_b), .out_if(if_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Per-instance views for the shared monitor loop.
  int   mon_d [2];
  int   mon_r [2];
  int   mon_c [2];
  logic mon_v [2];
  logic mon_l [2];
  logic mon_done [2];
  assign mon_d[0] = int'(if_a.out_data);
  assign mon_d[1] = int'(if_b.out_data);
  assign mon_r[0] = int'(if_a.out_row);
  assign mon_r[1] = int'(if_b.out_row);
  assign mon_c[0] = int'(if_a.out_col);
  assign mon_c[1] = int'(if_b.out_col);
  assign mon_v[0] = if_a.out_valid;
  assign mon_v[1] = if_b.out_valid;
  assign mon_l[0] = if_a.out_last;
  assign mon_l[1] = if_b.out_last;
  assign mon_done[0] = done_a;
  assign mon_done[1] = done_b;

  rec_t got0[$], got1[$], exp0[$], exp1[$];
  int   done_cnt [2];
  int   lat [2];
  int   edge_cnt = 0;
  int   start_edge = 0;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Capture handshakes and check that stalled outputs hold.
  initial begin
    bit   stall [2];
    rec_t prev [2];
    stall = '{0, 0};
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          stall[i] = 1'b0;
        end else begin
          if (stall[i]) begin
            check_val($sformatf("hold%0d_valid", i), mon_v[i], 1);
            check_val($sformatf("hold%0d_data", i), mon_d[i], prev[i].d);
            check_val($sformatf("hold%0d_row", i), mon_r[i], prev[i].r);
            check_val($sformatf("hold%0d_col", i), mon_c[i], prev[i].c);
            check_val($sformatf("hold%0d_last", i), mon_l[i], prev[i].l);
          end
          if (mon_v[i] && lat[i] < 0) lat[i] = edge_cnt - start_edge;
          prev[i].d = mon_d[i];
          prev[i].r = mon_r[i];
          prev[i].c = mon_c[i];
          prev[i].l = mon_l[i];
          stall[i]  = mon_v[i] && !rdy;
          if (mon_v[i] && rdy) begin
            if (i == 0) got0.push_back(prev[i]);
            else        got1.push_back(prev[i]);
          end
          if (mon_done[i]) done_cnt[i]++;
        end
      end
    end
  end

  function automatic int elem_of(input logic [255:0] map, input int r, input int c);
    logic [15:0] w;
    w = 16'(map >> ((r * 4 + c) * 16));
    return int'($signed(w));
  endfunction

  // Reference: each window reduced directly; average uses floor division.
  function automatic void build_exp(input logic [255:0] map, input bit m,
                                    input int s, input int which);
    int oh, ow;
    oh = (4 - 2) / s + 1;
    ow = (4 - 2) / s + 1;
    for (int orow = 0; orow < oh; orow++) begin
      for (int ocol = 0; ocol < ow; ocol++) begin
        int   v, sum, mx, q;
        rec_t e;
        sum = 0;
        mx  = -100000;
        for (int kr = 0; kr < 2; kr++) begin
          for (int kc = 0; kc < 2; kc++) begin
            v = elem_of(map, orow * s + kr, ocol * s + kc);
            sum += v;
            if (v > mx) mx = v;
          end
        end
        q = sum / 4;
        if ((sum % 4 != 0) && sum < 0) q = q - 1;
        e.d = m ? q : mx;
        e.r = orow;
        e.c = ocol;
        e.l = (orow == oh - 1) && (ocol == ow - 1);
        if (which == 0) exp0.push_back(e);
        else            exp1.push_back(e);
      end
    end
  endfunction

  // rpol: 0 = always ready, 1 = five-cycle stall on A's second output,
  // 2 = random ready. corner: restart/map-change attempt mid-run.
  task automatic run(input logic [255:0] map, input bit m, input int rpol,
                     input bit corner, input string tag);
    int cyc, bp_left;
    bit bp_used;
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    build_exp(map, m, 2, 0);
    build_exp(map, m, 1, 1);
    done_cnt = '{0, 0};
    lat      = '{-1, -1};
    @(posedge clk); #1;
    act_map = map; mode = m; start = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_edge = edge_cnt;
    cyc = 0; bp_left = 0; bp_used = 1'b0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (corner && cyc == 5) begin
        start = 1'b1; act_map = ~map; mode = ~m;
      end else begin
        start = 1'b0;
      end
      if (rpol == 2) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else if (rpol == 1) begin
        if (bp_left > 0) begin
          check_val({tag, "_bp_data"}, int'(if_a.out_data), exp0[1].d);
          check_val({tag, "_bp_busy"}, busy_a, 1);
          bp_left--;
          rdy = 1'b0;
        end else if (!bp_used && if_a.out_valid && got0.size() == 1) begin
          bp_used = 1'b1;
          bp_left = 4;
          rdy = 1'b0;
        end else begin
          rdy = 1'b1;
        end
      end else begin
        rdy = 1'b1;
      end
    end
    check_val({tag, "_timeout"}, (cyc < 400) ? 1 : 0, 1);
    rdy = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_val({tag, "_busy_a_end"}, busy_a, 0);
    check_val({tag, "_busy_b_end"}, busy_b, 0);
    check_val({tag, "_done_a_cnt"}, done_cnt[0], 1);
    check_val({tag, "_done_b_cnt"}, done_cnt[1], 1);
    check_val({tag, "_lat_a"}, lat[0], 4);
    check_val({tag, "_lat_b"}, lat[1], 4);
    check_val({tag, "_n_a"}, got0.size(), exp0.size());
    check_val({tag, "_n_b"}, got1.size(), exp1.size());
    for (int k = 0; k < got0.size() && k < exp0.size(); k++) begin
      check_val($sformatf("%s_a%0d_data", tag, k), got0[k].d, exp0[k].d);
      check_val($sformatf("%s_a%0d_row", tag, k), got0[k].r, exp0[k].r);
      check_val($sformatf("%s_a%0d_col", tag, k), got0[k].c, exp0[k].c);
      check_val($sformatf("%s_a%0d_last", tag, k), got0[k].l, exp0[k].l);
    end
    for (int k = 0; k < got1.size() && k < exp1.size(); k++) begin
      check_val($sformatf("%s_b%0d_data", tag, k), got1[k].d, exp1[k].d);
      check_val($sformatf("%s_b%0d_row", tag, k), got1[k].r, exp1[k].r);
      check_val($sformatf("%s_b%0d_col", tag, k), got1[k].c, exp1[k].c);
      check_val($sformatf("%s_b%0d_last", tag, k), got1[k].l, exp1[k].l);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy"}, busy_a, 0);
    check_val({tag, "_done"}, done_a, 0);
    check_val({tag, "_valid"}, if_a.out_valid, 0);
    check_val({tag, "_data"}, int'(if_a.out_data), 0);
    check_val({tag, "_row"}, if_a.out_row, 0);
    check_val({tag, "_col"}, if_a.out_col, 0);
    check_val({tag, "_last"}, if_a.out_last, 0);
    check_val({tag, "_valid_b"}, if_b.out_valid, 0);
    check_val({tag, "_busy_b"}, busy_b, 0);
  endtask

  logic [255:0] ramp, map_neg1, map_m3, map_min, rmap;

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; act_map = '0; rdy = 1'b1;
    lat = '{-1, -1};
    done_cnt = '{0, 0};
    for (int i = 0; i < 16; i++) begin
      ramp[i*16 +: 16]  = 16'(i);
      map_m3[i*16 +: 16] = 16'hFFFD;
      map_min[i*16 +: 16] = 16'h8000;
    end
    map_neg1 = '0;
    map_neg1[15:0] = 16'hFFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run(ramp, 1'b0, 0, 1'b0, "ramp_max");
    if (got0.size() == 4) begin
      check_val("ramp_max_w0", got0[0].d, 5);
      check_val("ramp_max_w3", got0[3].d, 15);
    end
    run(ramp, 1'b1, 0, 1'b0, "ramp_avg");
    if (got0.size() == 4) check_val("ramp_avg_w1", got0[1].d, 4);
    run(ramp, 1'b0, 1, 1'b0, "backpressure");
    run(ramp, 1'b0, 0, 1'b1, "corner");
    run(map_neg1, 1'b1, 0, 1'b0, "neg1_avg");
    if (got0.size() > 0) check_val("neg1_avg_w0", got0[0].d, -1);
    run(map_m3, 1'b1, 0, 1'b0, "m3_avg");
    if (got0.size() > 0) check_val("m3_avg_w0", got0[0].d, -3);
    run(map_min, 1'b0, 0, 1'b0, "min_max");
    if (got0.size() > 0) check_val("min_max_w0", got0[0].d, -32768);

    // Abort during ACCUM, then confirm a clean rerun.
    done_cnt = '{0, 0};
    @(posedge clk); #1;
    act_map = ramp; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_no_done", done_cnt[0] + done_cnt[1], 0);
    check_val("abort_idle", busy_a, 0);
    run(ramp, 1'b0, 0, 1'b0, "rerun");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) rmap[i*16 +: 16] = 16'($urandom);
      run(rmap, 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)),
          $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
